// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter: multi-port RS issue arbiter; per-port grant FSM, oldest-first selection
// with a starvation override driven by per-entry saturating wait counters.
module rs_issue_arbiter #(
  parameter int NUM_REQ    = 8,
  parameter int ISSUE_W    = 2,
  parameter int ROB_W      = 5,
  parameter int STARVE_LIM = 15,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ROB_W-1:0]   req_rob_idx,
  input  logic [ROB_W-1:0]                rob_head_idx,
  input  logic [NUM_REQ-1:0]              squash,
  input  logic [ISSUE_W-1:0]              port_ready,
  output logic [ISSUE_W-1:0]              gnt_valid,
  output logic [ISSUE_W-1:0][IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0]              issue_fire,
  output logic                            starve_active
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t st [ISSUE_W];
  logic [CW-1:0] cnt [NUM_REQ];
  logic [CW-1:0] cnt_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] live, held, avail, chosen, starve_nxt;
  logic [ROB_W:0] key [NUM_REQ];
  logic [ROB_W:0] best;
  logic [ISSUE_W-1:0] fire, sel, found, drop;
  logic [ISSUE_W-1:0][IDX_W-1:0] pick;
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_gv
    assign gnt_valid[g] = st[g] == HOLD;
  end
  always_comb begin
    live = req_valid & ~squash;
    held = '0;
    issue_fire = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      fire[p] = en && gnt_valid[p] && port_ready[p] && live[gnt_idx[p]];
      drop[p] = gnt_valid[p] && !live[gnt_idx[p]];
      sel[p] = !gnt_valid[p] || fire[p];
      for (int i = 0; i < NUM_REQ; i++) begin
        held[i] = held[i] || (gnt_valid[p] && gnt_idx[p] == IDX_W'(i));
        issue_fire[i] = issue_fire[i] || (fire[p] && gnt_idx[p] == IDX_W'(i));
      end
    end
    // key MSB is 0 for starved entries; the modular age sits below it
    for (int i = 0; i < NUM_REQ; i++)
      key[i] = {cnt[i] != CW'(STARVE_LIM), req_rob_idx[i] - rob_head_idx};
    avail = live & ~held;
    chosen = '0;
    best = '1;
    for (int p = 0; p < ISSUE_W; p++) begin
      found[p] = 1'b0;
      pick[p] = '0;
      best = '1;
      for (int i = 0; i < NUM_REQ; i++)
        if (sel[p] && avail[i] && !chosen[i] && (!found[p] || key[i] < best)) begin
          found[p] = 1'b1;
          pick[p] = IDX_W'(i);
          best = key[i];
        end
      for (int i = 0; i < NUM_REQ; i++)
        chosen[i] = chosen[i] || (found[p] && pick[p] == IDX_W'(i));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_nxt[i] = (!live[i] || held[i] || chosen[i]) ? '0 :
                   (cnt[i] == CW'(STARVE_LIM)) ? cnt[i] : cnt[i] + 1'b1;
      starve_nxt[i] = cnt_nxt[i] == CW'(STARVE_LIM);
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int p = 0; p < ISSUE_W; p++) st[p] <= IDLE;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      gnt_idx <= '0;
      starve_active <= 1'b0;
    end else if (en) begin
      for (int p = 0; p < ISSUE_W; p++) begin
        st[p] <= sel[p] ? (found[p] ? HOLD : IDLE) : (drop[p] ? IDLE : st[p]);
        if (sel[p] && found[p]) gnt_idx[p] <= pick[p];
      end
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= cnt_nxt[i];
      starve_active <= |starve_nxt;
    end
endmodule

// File: tb/tb_rs_issue_arbiter.sv
// tb_rs_issue_arbiter: directed checks of grant order, hold/fire, squash, starvation, en and reset.
module tb_rs_issue_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en;
  logic [7:0] req_valid;
  logic [7:0][4:0] req_rob_idx;
  logic [4:0] rob_head_idx;
  logic [7:0] squash;
  logic [1:0] port_ready;
  logic [1:0] gnt_valid;
  logic [1:0][2:0] gnt_idx;
  logic [7:0] issue_fire;
  logic starve_active;
  int total = 0;
  int bad = 0;

  rs_issue_arbiter dut (
    .clock(clock), .reset(reset), .en(en), .req_valid(req_valid),
    .req_rob_idx(req_rob_idx), .rob_head_idx(rob_head_idx), .squash(squash),
    .port_ready(port_ready), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
    .issue_fire(issue_fire), .starve_active(starve_active)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    en = 1'b1;
    req_valid = '0;
    req_rob_idx = '0;
    rob_head_idx = '0;
    squash = '0;
    port_ready = '0;
    tick();
    tick();
    chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
    chk("rst_gnt_idx", 32'(gnt_idx), 32'h0);
    chk("rst_starve", 32'(starve_active), 32'h0);
    chk("rst_fire", 32'(issue_fire), 32'h0);
    // release between edges with a request pending: grant only after the next edge
    req_valid = 8'h01;
    req_rob_idx[0] = 5'd3;
    #2 reset = 1'b1;
    #1 chk("rel_no_gnt", 32'(gnt_valid), 32'h0);
    tick();
    chk("first_gnt_valid", 32'(gnt_valid), 32'h1);
    chk("first_gnt_idx0", 32'(gnt_idx[0]), 32'h0);
    req_valid = '0;
    tick();
    chk("valid_drop_idle", 32'(gnt_valid), 32'h0);
    // age order: entry 3 (age 4) before entry 2 (age 7)
    rob_head_idx = 5'd0;
    req_rob_idx[2] = 5'd7;
    req_rob_idx[3] = 5'd4;
    req_valid = 8'h0C;
    port_ready = 2'b11;
    #1 chk("age_no_fire_yet", 32'(issue_fire), 32'h0);
    tick();
    chk("age_gnt_valid", 32'(gnt_valid), 32'h3);
    chk("age_port0", 32'(gnt_idx[0]), 32'h3);
    chk("age_port1", 32'(gnt_idx[1]), 32'h2);
    chk("age_fire", 32'(issue_fire), 32'h0C);
    tick();
    req_valid = '0;
    #1 chk("age_after_idle", 32'(gnt_valid), 32'h0);
    chk("age_after_fire", 32'(issue_fire), 32'h0);
    // ROB wrap: head=30, rob 31 (age 1) older than rob 2 (age 4)
    rob_head_idx = 5'd30;
    req_rob_idx[0] = 5'd2;
    req_rob_idx[1] = 5'd31;
    req_valid = 8'h03;
    port_ready = 2'b00;
    tick();
    chk("wrap_gnt_valid", 32'(gnt_valid), 32'h3);
    chk("wrap_port0", 32'(gnt_idx[0]), 32'h1);
    chk("wrap_port1", 32'(gnt_idx[1]), 32'h0);
    req_valid = '0;
    tick();
    chk("wrap_idle", 32'(gnt_valid), 32'h0);
    // stall: entry 4 held while port 0 not ready
    rob_head_idx = 5'd0;
    req_rob_idx[4] = 5'd9;
    req_valid = 8'h10;
    tick();
    chk("stall_gnt_valid", 32'(gnt_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_idx", 32'(gnt_idx[0]), 32'h4);
      chk("stall_no_fire", 32'(issue_fire), 32'h0);
    end
    port_ready = 2'b01;
    #1 chk("stall_fire", 32'(issue_fire), 32'h10);
    tick();
    req_valid = '0;
    #1 chk("stall_fire_once", 32'(issue_fire), 32'h0);
    chk("stall_idle", 32'(gnt_valid), 32'h0);
    // squash beats port_ready
    port_ready = 2'b00;
    req_valid = 8'h10;
    tick();
    chk("sq_gnt_idx", 32'(gnt_idx[0]), 32'h4);
    squash = 8'h10;
    port_ready = 2'b01;
    #1 chk("sq_no_fire", 32'(issue_fire), 32'h0);
    tick();
    squash = '0;
    req_valid = '0;
    #1 chk("sq_idle", 32'(gnt_valid), 32'h0);
    // starvation: entry 7 (age 20) loses to 0..3 every cycle
    for (int i = 0; i < 4; i++) req_rob_idx[i] = 5'(i);
    req_rob_idx[7] = 5'd20;
    req_valid = 8'h8F;
    port_ready = 2'b11;
    tick();
    chk("stv_port0", 32'(gnt_idx[0]), 32'h0);
    chk("stv_port1", 32'(gnt_idx[1]), 32'h1);
    chk("stv_fire", 32'(issue_fire), 32'h03);
    for (int k = 0; k < 13; k++) tick();
    chk("stv_not_yet", 32'(starve_active), 32'h0);
    tick();
    chk("stv_active", 32'(starve_active), 32'h1);
    chk("stv_fire15", 32'(issue_fire), 32'h03);
    tick();
    chk("stv_port0_e7", 32'(gnt_idx[0]), 32'h7);
    chk("stv_port1_e2", 32'(gnt_idx[1]), 32'h2);
    chk("stv_cleared", 32'(starve_active), 32'h0);
    chk("stv_fire16", 32'(issue_fire), 32'h84);
    // en low freezes everything and suppresses fire
    en = 1'b0;
    #1 chk("en_no_fire", 32'(issue_fire), 32'h0);
    tick();
    chk("en_hold_p0", 32'(gnt_idx[0]), 32'h7);
    chk("en_hold_p1", 32'(gnt_idx[1]), 32'h2);
    chk("en_hold_valid", 32'(gnt_valid), 32'h3);
    // async reset mid-HOLD
    en = 1'b1;
    port_ready = 2'b00;
    #2 reset = 1'b0;
    #1 chk("arst_gnt_valid", 32'(gnt_valid), 32'h0);
    chk("arst_gnt_idx", 32'(gnt_idx), 32'h0);
    chk("arst_starve", 32'(starve_active), 32'h0);
    port_ready = 2'b11;
    #1 chk("arst_fire", 32'(issue_fire), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
